// File: rtl/seq_frame_ctrl.sv
// Frame sequencer for a serial 10110 detector: accepts a word, shifts it out
// MSB-first on idata/data_en, waits a drain window, counts seqen pulses seen
// during the frame and hands back the hit count over a valid/ready port.
module seq_frame_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             idata,
  output logic             data_en,
  input  logic             seqen,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_hits,
  input  logic             res_ready,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0]    DRN_LAST = DW'(DRAIN - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN_ST, REPORT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    drn_cnt_q, drn_cnt_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             data_en_q, data_en_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_hits_q, res_hits_d;

  assign idata     = sh_q[WIDTH-1];
  assign data_en   = data_en_q;
  assign res_valid = res_valid_q;
  assign res_hits  = res_hits_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Next-state and datapath: hits are sampled in SHIFT/DRAIN and saturate;
  // the report captures the count including the final drain-edge sample.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    drn_cnt_d   = drn_cnt_q;
    hits_d      = hits_q;
    data_en_d   = data_en_q;
    res_valid_d = res_valid_q;
    res_hits_d  = res_hits_q;

    if ((state_q == SHIFT || state_q == DRAIN_ST) && seqen && hits_q != HIT_MAX)
      hits_d = hits_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d      = in_data;
          bit_cnt_d = '0;
          hits_d    = '0;
          data_en_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // After the last data bit the register has shifted out to all zeros,
        // so idata drops to 0 together with data_en.
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == BIT_LAST) begin
          data_en_d = 1'b0;
          drn_cnt_d = '0;
          state_d   = DRAIN_ST;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DRAIN_ST: begin
        if (drn_cnt_q == DRN_LAST) begin
          res_valid_d = 1'b1;
          res_hits_d  = hits_d;
          state_d     = REPORT;
        end else begin
          drn_cnt_d = drn_cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      hits_q      <= '0;
      data_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_hits_q  <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      hits_q      <= hits_d;
      data_en_q   <= data_en_d;
      res_valid_q <= res_valid_d;
      res_hits_q  <= res_hits_d;
    end
  end

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Bench for seq_frame_ctrl: directed and randomized frames against a
// frame-level model (word bits MSB-first, hits = saturated popcount of
// seqen over the sampled window). A second instance with a 2-bit counter
// and seqen tied high exercises saturation alongside every frame.
module tb_seq_frame_ctrl;
  localparam int W = 16;
  localparam int D = 2;
  localparam int N = W + D;

  logic          clk, reset, in_valid, seqen, res_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, idata, data_en, res_valid, busy;
  logic [4:0]    res_hits;
  logic          in_ready2, idata2, data_en2, res_valid2, busy2;
  logic [1:0]    res_hits2;
  logic          seqen_hi;

  int total = 0;
  int bad   = 0;

  seq_frame_ctrl #(.WIDTH(W), .CNT_W(5), .DRAIN(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .idata(idata), .data_en(data_en), .seqen(seqen),
    .res_valid(res_valid), .res_hits(res_hits), .res_ready(res_ready),
    .busy(busy));

  seq_frame_ctrl #(.WIDTH(W), .CNT_W(2), .DRAIN(D)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .idata(idata2), .data_en(data_en2), .seqen(seqen_hi),
    .res_valid(res_valid2), .res_hits(res_hits2), .res_ready(res_ready),
    .busy(busy2));

  assign seqen_hi = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: s[k] is the seqen level sampled at edge E0+k.
  task automatic run_frame(input logic [W-1:0] word, input logic [N:0] s,
                           input int bp, input bit offer);
    int exp_hits;
    exp_hits = 0;
    for (int k = 1; k <= N; k++) exp_hits += int'(s[k]);
    if (exp_hits > 31) exp_hits = 31;

    in_valid = 1'b1;
    in_data  = word;
    seqen    = s[0];
    chk("in_ready_before_accept", 32'(in_ready), 1);
    step();  // E0
    for (int k = 0; k < W; k++) begin
      chk("idata_bit", 32'(idata), 32'(word[W-1-k]));
      chk("data_en_shift", 32'(data_en), 1);
      chk("busy_shift", 32'(busy), 1);
      chk("in_ready_shift", 32'(in_ready), 0);
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      seqen    = s[k+1];
      step();
    end
    chk("data_en_drain", 32'(data_en), 0);
    chk("idata_drain", 32'(idata), 0);
    for (int d = 1; d <= D; d++) begin
      seqen = s[W+d];
      step();
      chk("res_valid_timing", 32'(res_valid), (d == D) ? 1 : 0);
    end
    chk("res_hits", 32'(res_hits), 32'(exp_hits));
    chk("res_hits_sat", 32'(res_hits2), 3);
    chk("busy_report", 32'(busy), 1);
    in_valid  = offer;
    in_data   = 16'hFFFF;
    res_ready = 1'b0;
    for (int b = 0; b < bp; b++) begin
      seqen = 1'($urandom);
      step();
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_hits", 32'(res_hits), 32'(exp_hits));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    res_ready = 1'b1;
    step();
    chk("res_valid_taken", 32'(res_valid), 0);
    chk("in_ready_after_take", 32'(in_ready), 1);
    chk("busy_after_take", 32'(busy), 0);
    res_ready = 1'b0;
    seqen     = 1'b0;
    if (!offer) in_valid = 1'b0;
  endtask

  initial begin
    logic [N:0] s;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; seqen = 1'b0; res_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_data_en", 32'(data_en), 0);
    chk("rst_idata", 32'(idata), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_hits", 32'(res_hits), 0);
    #14 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold_busy", 32'(busy), 0);
      chk("idle_hold_ready", 32'(in_ready), 1);
    end

    // Serialization + hit count with a pulse also offered while idle.
    s = '0; s[0] = 1'b1; s[5] = 1'b1; s[8] = 1'b1; s[17] = 1'b1;
    run_frame(16'hB6C0, s, 0, 1'b0);

    // Backpressure with 16'hFFFF offered, then that word accepted next.
    s = (N+1)'($urandom);
    run_frame(W'($urandom), s, 10, 1'b1);
    s = (N+1)'($urandom);
    run_frame(16'hFFFF, s, 1, 1'b0);

    // Abort during SHIFT.
    in_valid = 1'b1; in_data = W'($urandom); seqen = 1'b1;
    step();  // E0
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    #2 reset = 1'b0;
    #1;
    chk("abort_data_en", 32'(data_en), 0);
    chk("abort_idata", 32'(idata), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    #3 reset = 1'b1;
    seqen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_result", 32'(res_valid), 0);
    end
    run_frame(W'($urandom), '0, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      s = (N+1)'($urandom);
      run_frame(W'($urandom), s, int'($urandom_range(0, 3)), 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_frame_ctrl.md
Name: seq_frame_ctrl

Overview:
- Frame sequencer for the serial 10110 sequence detector (the detector's ports are idata, data_en and seqen).
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto the detector's idata/data_en inputs.
- Waits a fixed drain window, counts seqen pulses seen during the frame, and returns the hit count over a second valid/ready handshake.

Parameters:
- WIDTH, 16, bits per frame word; legal range is WIDTH >= 2.
- CNT_W, 5, width of the hit counter; the counter saturates at 2^CNT_W-1.
- DRAIN, 2, cycles after the last bit with data_en low, so detector latency can settle; legal range is DRAIN >= 1.

Ports:
- clk  input  1  single clock; all flops update on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame word offered.
- in_data  input  WIDTH  frame word; the MSB is transmitted first.
- in_ready  output  1  controller can accept a word. High only in IDLE.
- idata  output  1  serial bit to the detector.
- data_en  output  1  bit-valid to the detector.
- seqen  input  1  match pulse from the detector.
- res_valid  output  1  result available.
- res_hits  output  CNT_W  number of matches in the frame.
- res_ready  input  1  result consumer ready.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, shift register=0, bit counter=0, drain counter=0, hits=0.
  - idata=0, data_en=0, res_valid=0, res_hits=0, busy=0, in_ready=1.
- Outputs:
  - idata = MSB of the shift register (a flop).
  - data_en is a flop.
  - in_ready and busy are decoded from state.
- IDLE:
  - On in_valid&&in_ready at edge E0: load in_data into the shift register, bit counter=0, hits=0, data_en<=1, go to SHIFT.
  - idata shows in_data[WIDTH-1] from E0.
- SHIFT:
  - Each edge shifts left by one, fills the LSB with 0, and increments the bit counter.
  - Bits WIDTH-1..0 are presented on edges E0..E0+WIDTH-1, one bit per cycle, with data_en=1 throughout.
  - At edge E0+WIDTH: data_en<=0, idata=0, drain counter=0, go to DRAIN.
- DRAIN:
  - Counts DRAIN cycles.
  - At edge E0+WIDTH+DRAIN: res_valid<=1, res_hits<=hits, go to REPORT.
- REPORT:
  - res_valid and res_hits are held stable until res_valid&&res_ready is sampled at an edge.
  - At that edge: res_valid<=0, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Hit counting:
  - seqen is sampled at every edge while in SHIFT or DRAIN, i.e. edges E0+1 through E0+WIDTH+DRAIN inclusive.
  - Each sampled 1 adds 1 to hits; the counter saturates at 2^CNT_W-1 and does not wrap.
  - seqen is ignored in IDLE and REPORT.
  - A seqen held high for k sampled cycles counts k.
- Handshake rules:
  - in_valid while not in IDLE is ignored; the word is not stored.
  - res_ready outside REPORT has no effect.
  - in_data is sampled only on the accept edge; later changes do not affect the frame in flight.
- Reset mid-operation: the frame is discarded and all outputs take their reset values immediately (asynchronously). No res_valid is produced for the aborted frame.
- Frame latency, accept to res_valid: WIDTH+DRAIN cycles (18 with defaults).
- Minimum frame period: WIDTH+DRAIN+2 cycles, given res_ready=1.

Test Plan:
- Reset: pull reset low in the middle of a cycle -> immediately in_ready=1, and data_en, idata, res_valid, busy, res_hits all 0. Release it and hold in_valid=0 -> state stays IDLE.
- Serialization: in_data=16'hB6C0 accepted at E0 -> idata=1,0,1,1,0,1,1,0,1,1,0,0,0,0,0,0 on edges E0..E0+15 with data_en=1. data_en=0 from E0+16; res_valid=1 at E0+18; busy=1 from E0 until the result is taken.
- Hit count: a seqen stub pulses one cycle each at E0+5, E0+8 and E0+17, plus one pulse while in IDLE -> res_hits=3.
- Saturation: CNT_W=2 with seqen held high for the whole frame -> res_hits=3, not 18 mod 4 = 2.
- Backpressure: res_ready=0 for 10 cycles after res_valid, with in_valid=1 offering 16'hFFFF -> res_valid and res_hits stay stable, in_ready=0 and the word is not accepted. Then set res_ready=1 -> res_valid=0 next edge, then in_ready=1, and 16'hFFFF is accepted one cycle after that.
- Abort: assert reset low at E0+7, during SHIFT -> data_en=0 and idata=0 immediately. After release there is no res_valid, and the next frame starts cleanly with hits=0.
